// File: rtl/cfu_conv1d_initiator.sv
// cfu_conv1d_initiator: sequences one complete conv1d job over the CFU cmd/rsp
// handshake (init, kernel, bias, size, input words, start, output readback).
// Input words are read from a source-memory port. Readback words are written
// to a destination-memory port.
// Optional feature macro: CFU_SEQ_TIMEOUT_EN adds a response watchdog. When it
// fires, the job ends with err=1.
module cfu_conv1d_initiator #(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       length,
    input  logic [31:0]       bias,
    input  logic [31:0]       kernel_w0,
    input  logic [31:0]       kernel_w1,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              src_rd_en,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [31:0]       src_rdata,
    output logic              dst_wr_en,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [31:0]       dst_wdata,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [9:0]        cmd_payload_function_id,
    output logic [31:0]       cmd_payload_inputs_0,
    output logic [31:0]       cmd_payload_inputs_1,
    input  logic              rsp_valid,
    output logic              rsp_ready,
    input  logic [31:0]       rsp_payload_outputs_0
);
    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_CMD, S_WAIT_RSP, S_FETCH, S_CAPTURE, S_GAP, S_FINISH
    } state_t;

    // Which command of the fixed job sequence is currently outstanding.
    typedef enum logic [2:0] {
        P_INIT, P_K0, P_K1, P_BIAS, P_SIZE, P_INPUT, P_START, P_READ
    } phase_t;

    localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;

    state_t      r_state, w_state_next;
    phase_t      r_phase;
    logic [31:0] r_length, r_bias, r_kw0, r_kw1;
    logic [31:0] r_idx;
    logic [6:0]  r_funct7;
    logic [31:0] r_in0, r_in1;
    logic        r_err;
    logic        r_dst_wr_en;
    logic [ADDR_W-1:0] r_dst_addr;
    logic [31:0] r_dst_wdata;

    logic [31:0] w_n_words;
    logic        w_reject;
    logic        w_last_idx;
    logic        w_rsp_hs;
    logic        w_cmd_active;
    logic        w_timeout;

    assign w_n_words    = {2'b00, r_length[31:2]};
    assign w_reject     = (r_length == 32'd0) || (r_length[1:0] != 2'b00) ||
                          (r_length > 32'd1024) || ({1'b0, w_n_words} > MAX_WORDS);
    assign w_last_idx   = (r_idx == w_n_words - 32'd1);
    // Responses are accepted in every cycle outside reset, so stray ones drain.
    assign rsp_ready    = ~reset;
    assign w_rsp_hs     = rsp_valid && rsp_ready;
    assign w_cmd_active = (r_state == S_CMD) || (r_state == S_WAIT_RSP);

    assign src_addr                = r_idx[ADDR_W-1:0];
    assign dst_wr_en               = r_dst_wr_en;
    assign dst_addr                = r_dst_addr;
    assign dst_wdata               = r_dst_wdata;
    assign cmd_payload_function_id = {r_funct7, 3'b000};
    assign cmd_payload_inputs_0    = r_in0;
    assign cmd_payload_inputs_1    = r_in1;

`ifdef CFU_SEQ_TIMEOUT_EN
    logic [31:0] r_timer;

    // Watchdog: restarts with every command (a gap cycle always precedes one).
    always_ff @(posedge clk) begin
        if (reset)             r_timer <= 32'd0;
        else if (w_cmd_active) r_timer <= r_timer + 32'd1;
        else                   r_timer <= 32'd0;
    end

    assign w_timeout = w_cmd_active && (r_timer == 32'(TIMEOUT_CYCLES - 1));
`else
    // No watchdog; the expression is constant 0 and the sequencer waits forever.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state decode and handshake/status outputs.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        cmd_valid    = 1'b0;
        src_rd_en    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_CHECK;
            end
            S_CHECK: begin
                busy         = 1'b1;
                w_state_next = w_reject ? S_FINISH : S_CMD;
            end
            S_CMD, S_WAIT_RSP: begin
                busy      = 1'b1;
                cmd_valid = 1'b1;
                // Only a response retires the command; cmd_ready just moves us to waiting.
                if (w_rsp_hs)                          w_state_next = S_GAP;
                else if (w_timeout)                    w_state_next = S_FINISH;
                else if (r_state == S_CMD && cmd_ready) w_state_next = S_WAIT_RSP;
            end
            S_GAP: begin
                busy = 1'b1;
                if (r_phase == P_READ && w_last_idx)
                    w_state_next = S_FINISH;
                else if (r_phase == P_SIZE || (r_phase == P_INPUT && !w_last_idx))
                    w_state_next = S_FETCH;
                else
                    w_state_next = S_CMD;
            end
            S_FETCH: begin
                busy         = 1'b1;
                src_rd_en    = 1'b1;
                w_state_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                busy         = 1'b1;
                w_state_next = S_CMD;
            end
            S_FINISH: begin
                done         = 1'b1;
                err          = r_err;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Job context, command payload, and readback write registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase     <= P_INIT;
            r_length    <= 32'd0;
            r_bias      <= 32'd0;
            r_kw0       <= 32'd0;
            r_kw1       <= 32'd0;
            r_idx       <= 32'd0;
            r_funct7    <= 7'd0;
            r_in0       <= 32'd0;
            r_in1       <= 32'd0;
            r_err       <= 1'b0;
            r_dst_wr_en <= 1'b0;
            r_dst_addr  <= '0;
            r_dst_wdata <= 32'd0;
        end else begin
            r_dst_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_length <= length;
                        r_bias   <= bias;
                        r_kw0    <= kernel_w0;
                        r_kw1    <= kernel_w1;
                        r_err    <= 1'b0;
                        r_phase  <= P_INIT;
                        r_idx    <= 32'd0;
                        r_funct7 <= 7'd0;
                        r_in0    <= 32'd0;
                        r_in1    <= 32'd0;
                    end
                end
                S_CHECK: begin
                    if (w_reject) r_err <= 1'b1;
                end
                S_CMD, S_WAIT_RSP: begin
                    if (w_rsp_hs) begin
                        if (r_phase == P_READ) begin
                            r_dst_wr_en <= 1'b1;
                            r_dst_addr  <= r_idx[ADDR_W-1:0];
                            r_dst_wdata <= rsp_payload_outputs_0;
                        end
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end
                end
                S_GAP: begin
                    // Payload only changes here, while cmd_valid is low.
                    r_in1 <= 32'd0;
                    case (r_phase)
                        P_INIT: begin
                            r_phase <= P_K0;   r_funct7 <= 7'd2; r_in0 <= 32'd0; r_in1 <= r_kw0;
                        end
                        P_K0: begin
                            r_phase <= P_K1;   r_funct7 <= 7'd2; r_in0 <= 32'd1; r_in1 <= r_kw1;
                        end
                        P_K1: begin
                            r_phase <= P_BIAS; r_funct7 <= 7'd8; r_in0 <= r_bias;
                        end
                        P_BIAS: begin
                            r_phase <= P_SIZE; r_funct7 <= 7'd4; r_in0 <= r_length;
                        end
                        P_SIZE: begin
                            r_phase <= P_INPUT; r_funct7 <= 7'd1; r_idx <= 32'd0; r_in0 <= 32'd0;
                        end
                        P_INPUT: begin
                            if (w_last_idx) begin
                                r_phase <= P_START; r_funct7 <= 7'd5; r_in0 <= 32'd0;
                            end else begin
                                r_idx <= r_idx + 32'd1; r_in0 <= r_idx + 32'd1;
                            end
                        end
                        P_START: begin
                            r_phase <= P_READ; r_funct7 <= 7'd3; r_idx <= 32'd0; r_in0 <= 32'd0;
                        end
                        P_READ: begin
                            if (!w_last_idx) begin
                                r_idx <= r_idx + 32'd1; r_in0 <= r_idx + 32'd1;
                            end
                        end
                        default: r_phase <= P_INIT;
                    endcase
                end
                S_CAPTURE: begin
                    r_in1 <= src_rdata;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cfu_conv1d_initiator.sv
// Bench for cfu_conv1d_initiator: behavioural CFU responder, source memory and
// scoreboard of expected commands / destination writes.
`timescale 1ns/1ps
module tb_cfu_conv1d_initiator;
    localparam int ADDR_W = 8;
    localparam int TMO    = 16;

    logic              clk = 1'b0;
    logic              reset, start;
    logic [31:0]       length, bias, kernel_w0, kernel_w1;
    logic              busy, done, err;
    logic              src_rd_en;
    logic [ADDR_W-1:0] src_addr;
    logic [31:0]       src_rdata;
    logic              dst_wr_en;
    logic [ADDR_W-1:0] dst_addr;
    logic [31:0]       dst_wdata;
    logic              cmd_valid, cmd_ready;
    logic [9:0]        cmd_payload_function_id;
    logic [31:0]       cmd_payload_inputs_0, cmd_payload_inputs_1;
    logic              rsp_valid, rsp_ready;
    logic [31:0]       rsp_payload_outputs_0;

    always #5 clk = ~clk;

    cfu_conv1d_initiator #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .length(length), .bias(bias),
        .kernel_w0(kernel_w0), .kernel_w1(kernel_w1),
        .busy(busy), .done(done), .err(err),
        .src_rd_en(src_rd_en), .src_addr(src_addr), .src_rdata(src_rdata),
        .dst_wr_en(dst_wr_en), .dst_addr(dst_addr), .dst_wdata(dst_wdata),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_payload_function_id(cmd_payload_function_id),
        .cmd_payload_inputs_0(cmd_payload_inputs_0),
        .cmd_payload_inputs_1(cmd_payload_inputs_1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_payload_outputs_0(rsp_payload_outputs_0)
    );

    typedef struct { logic [9:0] fid; logic [31:0] in0; logic [31:0] in1; } cmd_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } dst_t;

    cmd_t        exp_cmd_q[$];
    dst_t        exp_dst_q[$];
    logic [31:0] src_mem [0:255];

    int n_checks = 0, n_pass = 0;
    int n_done = 0, n_valid_cycles = 0, n_dst_wr = 0, n_exec = 0, m_last_run = 0;
    int m_stall = 0, m_delay = 0;
    bit m_hang5 = 1'b0, m_stray = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
    endtask

    // Byte-wise dot product; byte 0 sits in [31:24].
    function automatic logic [31:0] dot4(input logic [31:0] a, input logic [31:0] k);
        logic [31:0] s = 32'd0;
        for (int j = 0; j < 4; j++)
            s = s + 32'(a[8*(3-j) +: 8]) * 32'(k[8*(3-j) +: 8]);
        return s;
    endfunction

    function automatic void push_cmd(input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
        cmd_t c;
        c.fid = {f7, 3'b000}; c.in0 = a; c.in1 = b;
        exp_cmd_q.push_back(c);
    endfunction

    function automatic void push_job(input logic [31:0] len, input bit with_read);
        int n;
        dst_t d;
        n = int'(len / 4);
        push_cmd(7'd0, 32'd0, 32'd0);
        push_cmd(7'd2, 32'd0, kernel_w0);
        push_cmd(7'd2, 32'd1, kernel_w1);
        push_cmd(7'd8, bias, 32'd0);
        push_cmd(7'd4, len, 32'd0);
        for (int i = 0; i < n; i++) push_cmd(7'd1, 32'(i), src_mem[i]);
        push_cmd(7'd5, 32'd0, 32'd0);
        if (with_read) begin
            for (int i = 0; i < n; i++) begin
                push_cmd(7'd3, 32'(i), 32'd0);
                d.addr = 32'(i);
                d.data = bias + dot4(src_mem[i], kernel_w0);
                exp_dst_q.push_back(d);
            end
        end
    endfunction

    // Source memory: data appears one cycle after the read strobe.
    initial begin
        bit pend = 1'b0;
        logic [ADDR_W-1:0] pa = '0;
        src_rdata = 32'hDEADBEEF;
        forever begin
            @(negedge clk);
            src_rdata = pend ? src_mem[pa] : 32'hDEADBEEF;
            pend = src_rd_en;
            pa   = src_addr;
        end
    end

    // Behavioural CFU: one command at a time, re-arms only after seeing cmd_valid low.
    initial begin
        bit          m_busy = 1'b0, need_low = 1'b0;
        int          cnt = 0, stall_cnt = 0;
        logic [31:0] rdata = 32'd0, m_k0 = 32'd0, m_b = 32'd0;
        logic [31:0] m_acc [0:255];
        cmd_t        c, e;
        cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_payload_outputs_0 = 32'hBAD0BAD0;
        forever begin
            @(negedge clk);
            cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_payload_outputs_0 = 32'hBAD0BAD0;
            if (reset) begin
                m_busy = 1'b0; need_low = 1'b0; stall_cnt = m_stall;
            end else if (m_stray) begin
                rsp_valid = 1'b1; rsp_payload_outputs_0 = 32'h5A5A5A5A; m_stray = 1'b0;
            end else if (m_busy) begin
                if (cnt == 0) begin
                    rsp_valid = 1'b1; rsp_payload_outputs_0 = rdata;
                    m_busy = 1'b0; need_low = 1'b1;
                end else if (cnt > 0) cnt--;
            end else if (need_low) begin
                if (!cmd_valid) need_low = 1'b0;
            end else if (!cmd_valid) begin
                stall_cnt = m_stall;
            end else if (stall_cnt > 0) begin
                stall_cnt--;
            end else begin
                cmd_ready = 1'b1;
                n_exec++;
                c.fid = cmd_payload_function_id; c.in0 = cmd_payload_inputs_0; c.in1 = cmd_payload_inputs_1;
                if (exp_cmd_q.size() == 0) begin
                    check("cmd_expected", 32'(exp_cmd_q.size()), 32'd1);
                end else begin
                    e = exp_cmd_q.pop_front();
                    check($sformatf("cmd%0d_fid", n_exec), 32'(c.fid), 32'(e.fid));
                    check($sformatf("cmd%0d_in0", n_exec), c.in0, e.in0);
                    check($sformatf("cmd%0d_in1", n_exec), c.in1, e.in1);
                end
                rdata = 32'h1111_0000 | 32'(c.fid);
                case (c.fid[9:3])
                    7'd2: if (c.in0 == 32'd0) m_k0 = c.in1;
                    7'd8: m_b = c.in0;
                    7'd1: m_acc[c.in0[7:0]] = m_b + dot4(c.in1, m_k0);
                    7'd3: rdata = m_acc[c.in0[7:0]];
                    default: ;
                endcase
                m_busy = 1'b1;
                cnt = (m_hang5 && c.fid[9:3] == 7'd5) ? -1 : m_delay;
            end
        end
    end

    // Monitor: payload hold, gap after response, destination writes, counters.
    initial begin
        bit          pv = 1'b0, phs = 1'b0;
        logic [9:0]  pf = '0;
        logic [31:0] p0 = '0, p1 = '0;
        int          run = 0;
        dst_t        d;
        forever begin
            @(negedge clk); #1;
            if (reset) begin
                pv = 1'b0; phs = 1'b0; run = 0;
            end else begin
                if (pv && !phs && !done)
                    check("hold", 32'(cmd_valid && cmd_payload_function_id == pf &&
                          cmd_payload_inputs_0 == p0 && cmd_payload_inputs_1 == p1), 32'd1);
                if (pv && phs) check("gap", 32'(cmd_valid), 32'd0);
                if (cmd_valid) begin
                    n_valid_cycles++; run++;
                end else if (run > 0) begin
                    m_last_run = run; run = 0;
                end
                if (done) n_done++;
                if (dst_wr_en) begin
                    n_dst_wr++;
                    if (exp_dst_q.size() == 0) check("dst_expected", 32'(exp_dst_q.size()), 32'd1);
                    else begin
                        d = exp_dst_q.pop_front();
                        $display("dst write addr=%0d data=0x%08h", dst_addr, dst_wdata);
                        check("dst_addr", 32'(dst_addr), d.addr);
                        check("dst_data", dst_wdata, d.data);
                    end
                end
                pv = cmd_valid; phs = rsp_valid && rsp_ready;
                pf = cmd_payload_function_id; p0 = cmd_payload_inputs_0; p1 = cmd_payload_inputs_1;
            end
        end
    end

    // One job: start at a negedge, cycle-1/cycle-2 timing, then bounded wait for done.
    task automatic run_job(input string tag, input logic [31:0] len, input bit issue,
                           input bit exp_err, input bit with_read, input bit glitch);
        int  d0, v0, cyc;
        bit  glitched;
        d0 = n_done; v0 = n_valid_cycles; glitched = 1'b0;
        if (issue) push_job(len, with_read);
        @(negedge clk); length = len; start = 1'b1;
        @(negedge clk); start = 1'b0; length = 32'd0;
        check({tag, "_busy_c1"}, 32'(busy), 32'd1);
        check({tag, "_cmdv_c1"}, 32'(cmd_valid), 32'd0);
        @(negedge clk);
        if (issue) check({tag, "_cmdv_c2"}, 32'(cmd_valid), 32'd1);
        else begin
            check({tag, "_done_c2"}, 32'(done), 32'd1);
            check({tag, "_err_c2"}, 32'(err), 32'd1);
        end
        cyc = 0;
        while (!done && cyc < 5000) begin
            if (glitch && !glitched && cmd_valid && cmd_payload_function_id == 10'h008) begin
                start = 1'b1; length = 32'd12; glitched = 1'b1;
            end else start = 1'b0;
            @(negedge clk); cyc++;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_done_count"}, 32'(n_done - d0), 32'd1);
        if (!issue) check({tag, "_no_cmdv"}, 32'(n_valid_cycles - v0), 32'd0);
        check({tag, "_cmdq_left"}, 32'(exp_cmd_q.size()), 32'd0);
        check({tag, "_dstq_left"}, 32'(exp_dst_q.size()), 32'd0);
        $display("job %s len=%0d done err=%0d cycles=%0d", tag, len, exp_err, cyc);
    endtask

    initial begin
        int d0, v0, w0, cyc;
        bit strobe_seen;
        reset = 1'b1; start = 1'b0; length = 32'd0;
        bias = 32'd1; kernel_w0 = 32'h02020202; kernel_w1 = 32'h02020202;
        for (int i = 0; i < 256; i++) src_mem[i] = 32'(i) * 32'h01010101;
        src_mem[0] = 32'h07060504; src_mem[1] = 32'h03020100;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_cmdv", 32'(cmd_valid), 32'd0);
        check("rst_src_rd", 32'(src_rd_en), 32'd0);
        check("rst_dst_wr", 32'(dst_wr_en), 32'd0);
        check("rst_rsp_ready", 32'(rsp_ready), 32'd0);
        check("rst_fid", 32'(cmd_payload_function_id), 32'd0);
        check("rst_in0", cmd_payload_inputs_0, 32'd0);
        check("rst_in1", cmd_payload_inputs_1, 32'd0);
        check("rst_src_addr", 32'(src_addr), 32'd0);
        check("rst_dst_addr", 32'(dst_addr), 32'd0);
        check("rst_dst_wdata", dst_wdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_rsp_ready", 32'(rsp_ready), 32'd1);

        // Basic job, immediate responder: 10 commands, 2 readback words (45, 13).
        run_job("j1", 32'd8, 1'b1, 1'b0, 1'b1, 1'b0);
        // Stalled ready and slow responses.
        m_stall = 5; m_delay = 20;
        run_job("j2", 32'd8, 1'b1, 1'b0, 1'b1, 1'b0);
        m_stall = 0; m_delay = 0;

        // Rejected lengths.
        run_job("rej6", 32'd6, 1'b0, 1'b1, 1'b0, 1'b0);
        run_job("rej0", 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_job("rej2048", 32'd2048, 1'b0, 1'b1, 1'b0, 1'b0);

        // Stray response while idle.
        d0 = n_done; v0 = n_valid_cycles; w0 = n_dst_wr;
        m_stray = 1'b1;
        repeat (4) @(negedge clk);
        check("stray_busy", 32'(busy), 32'd0);
        check("stray_dst", 32'(n_dst_wr - w0), 32'd0);
        check("stray_done", 32'(n_done - d0), 32'd0);
        check("stray_cmdv", 32'(n_valid_cycles - v0), 32'd0);
        $display("stray response drained");

        // Start pulsed during the input phase is ignored.
        run_job("glitch", 32'd8, 1'b1, 1'b0, 1'b1, 1'b1);

        // Reset during the second input command.
        d0 = n_done;
        push_job(32'd8, 1'b1);
        @(negedge clk); length = 32'd8; start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (!(cmd_valid && cmd_payload_function_id == 10'h008 && cmd_payload_inputs_0 == 32'd1)
               && cyc < 2000) begin
            @(negedge clk); cyc++;
        end
        check("rst_mid_found", 32'(cmd_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_cmdv", 32'(cmd_valid), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        reset = 1'b0;
        exp_cmd_q.delete(); exp_dst_q.delete();
        strobe_seen = 1'b0; w0 = n_dst_wr;
        repeat (6) begin
            @(negedge clk);
            if (src_rd_en || cmd_valid) strobe_seen = 1'b1;
        end
        check("rst_mid_quiet", 32'(strobe_seen), 32'd0);
        check("rst_mid_no_dst", 32'(n_dst_wr - w0), 32'd0);
        check("rst_mid_no_done", 32'(n_done - d0), 32'd0);
        $display("reset mid-job handled");
        run_job("after_rst", 32'd8, 1'b1, 1'b0, 1'b1, 1'b0);

`ifdef CFU_SEQ_TIMEOUT_EN
        // Responder never answers funct7 5: watchdog ends the job, no readback.
        m_hang5 = 1'b1;
        run_job("tmo", 32'd8, 1'b1, 1'b1, 1'b0, 1'b0);
        check("tmo_valid_cycles", 32'(m_last_run), 32'(TMO));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
